// File: rtl/vector_sequencer.sv
// Vector sequencer: buffers host test vectors in a FIFO and paces them one per
// test cycle, producing load/transfer strobes for double-buffered formatter channels.
module vector_sequencer #(
  parameter int NUM_CH     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int NCYC_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  input  logic [7:0]        CYCLE_LENGTH,
  input  logic [NCYC_W-1:0] NUM_CYCLES,
  input  logic              VEC_VALID,
  output logic              VEC_READY,
  input  logic [NUM_CH-1:0] VEC_DATA,
  input  logic [NUM_CH-1:0] VEC_FF,
  input  logic              VEC_TSEL,
  output logic [NUM_CH-1:0] D_OUT,
  output logic [NUM_CH-1:0] FF_OUT,
  output logic              LOAD_SIG,
  output logic              LOAD_FF,
  output logic              TRANSFER_SIG,
  output logic              TRANSFER_FF,
  output logic              TEST_CYCLE,
  output logic              EN_FF_LOGIC,
  output logic              BUSY,
  output logic              DONE,
  output logic              UNDERRUN,
  output logic [NCYC_W-1:0] CYC_CNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 2 * NUM_CH + 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_ARM, S_RUN, S_FINISH} state_t;

  // Handshake: a vector transfers on any CLK edge where VEC_VALID && VEC_READY.
  // The host holds VEC_DATA/VEC_FF/VEC_TSEL stable until that edge.
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              push, pop, empty;
  logic [EW-1:0]     head;

  state_t            state;
  logic [7:0]        phase, len_q;
  logic [NCYC_W-1:0] ncyc_q;
  logic [NCYC_W:0]   cnt_inc;
  logic              load_slot, last_cycle, pend_tsel;

  assign empty      = (count == '0);
  assign VEC_READY  = (count != FULL_CNT);
  assign push       = VEC_VALID & VEC_READY;
  assign head       = mem[rd_ptr];
  assign BUSY       = (state != S_IDLE);
  assign LOAD_FF    = LOAD_SIG;
  assign TRANSFER_FF = TRANSFER_SIG;

  // One extra bit so the count+1 comparisons stay exact at the counter limit.
  assign cnt_inc    = {1'b0, CYC_CNT} + {{NCYC_W{1'b0}}, 1'b1};
  assign load_slot  = (cnt_inc < {1'b0, ncyc_q});
  assign last_cycle = (cnt_inc == {1'b0, ncyc_q});

  always_comb begin
    pop = 1'b0;
    if (!STOP && !empty) begin
      if (state == S_PRIME)
        pop = 1'b1;
      else if (state == S_RUN && phase == '0 && load_slot)
        pop = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= {VEC_TSEL, VEC_FF, VEC_DATA};
  end

  always_ff @(posedge CLK) begin
    if (RST || STOP) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      phase        <= '0;
      len_q        <= '0;
      ncyc_q       <= '0;
      CYC_CNT      <= '0;
      UNDERRUN     <= 1'b0;
      pend_tsel    <= 1'b0;
      D_OUT        <= '0;
      FF_OUT       <= '0;
      LOAD_SIG     <= 1'b0;
      TRANSFER_SIG <= 1'b0;
      TEST_CYCLE   <= 1'b0;
      EN_FF_LOGIC  <= 1'b0;
      DONE         <= 1'b0;
    end else begin
      LOAD_SIG     <= 1'b0;
      TRANSFER_SIG <= 1'b0;
      DONE         <= 1'b0;
      if (STOP) begin
        state       <= S_IDLE;
        EN_FF_LOGIC <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (START) begin
              if (NUM_CYCLES == '0) begin
                DONE <= 1'b1;
              end else begin
                len_q    <= (CYCLE_LENGTH < 8'd2) ? 8'd2 : CYCLE_LENGTH;
                ncyc_q   <= NUM_CYCLES;
                CYC_CNT  <= '0;
                UNDERRUN <= 1'b0;
                state    <= S_PRIME;
              end
            end
          end
          S_PRIME: begin
            if (pop) begin
              LOAD_SIG  <= 1'b1;
              D_OUT     <= head[NUM_CH-1:0];
              FF_OUT    <= head[2*NUM_CH-1:NUM_CH];
              pend_tsel <= head[EW-1];
              state     <= S_ARM;
            end
          end
          S_ARM: begin
            TRANSFER_SIG <= 1'b1;
            TEST_CYCLE   <= pend_tsel;
            phase        <= '0;
            EN_FF_LOGIC  <= 1'b1;
            state        <= S_RUN;
          end
          S_RUN: begin
            // An empty FIFO at a load slot leaves pend_tsel/D_OUT untouched,
            // so the channels simply repeat the previous vector.
            if (phase == '0 && load_slot) begin
              if (pop) begin
                LOAD_SIG  <= 1'b1;
                D_OUT     <= head[NUM_CH-1:0];
                FF_OUT    <= head[2*NUM_CH-1:NUM_CH];
                pend_tsel <= head[EW-1];
              end else begin
                UNDERRUN <= 1'b1;
              end
            end
            if (phase == len_q - 8'd1) begin
              CYC_CNT <= cnt_inc[NCYC_W-1:0];
              phase   <= '0;
              if (last_cycle) begin
                state <= S_FINISH;
              end else begin
                TRANSFER_SIG <= 1'b1;
                TEST_CYCLE   <= pend_tsel;
              end
            end else begin
              phase <= phase + 8'd1;
            end
          end
          S_FINISH: begin
            EN_FF_LOGIC <= 1'b0;
            DONE        <= 1'b1;
            state       <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: each scenario task drives a run, records
// strobe positions per sample, and compares them against hand-derived values.
module tb_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stop, vec_valid, vec_ready, vec_tsel;
  logic [7:0]  cycle_length, vec_data, vec_ff, d_out, ff_out;
  logic [15:0] num_cycles, cyc_cnt;
  logic        load_sig, load_ff, transfer_sig, transfer_ff, test_cycle;
  logic        en_ff_logic, busy, done, underrun;

  int total = 0;
  int bad   = 0;

  // Per-run trace: bit k of each vector is set when the strobe was seen at sample k.
  logic [63:0] load_bits, xfer_bits, done_bits;
  logic [7:0]  tc_bits;
  logic [15:0] load_q[$];
  int          under_k, overlap, busy_cnt, next_val;

  always #5 clk = ~clk;

  vector_sequencer dut (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop),
    .CYCLE_LENGTH(cycle_length), .NUM_CYCLES(num_cycles),
    .VEC_VALID(vec_valid), .VEC_READY(vec_ready), .VEC_DATA(vec_data),
    .VEC_FF(vec_ff), .VEC_TSEL(vec_tsel), .D_OUT(d_out), .FF_OUT(ff_out),
    .LOAD_SIG(load_sig), .LOAD_FF(load_ff), .TRANSFER_SIG(transfer_sig),
    .TRANSFER_FF(transfer_ff), .TEST_CYCLE(test_cycle), .EN_FF_LOGIC(en_ff_logic),
    .BUSY(busy), .DONE(done), .UNDERRUN(underrun), .CYC_CNT(cyc_cnt)
  );

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; vec_valid = 1'b0;
    vec_data = '0; vec_ff = '0; vec_tsel = 1'b0;
    cycle_length = '0; num_cycles = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_vec(input logic [7:0] d, input logic [7:0] f, input logic t);
    vec_valid = 1'b1; vec_data = d; vec_ff = f; vec_tsel = t;
    @(negedge clk);
    vec_valid = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] cl, input logic [15:0] nc);
    start = 1'b1; cycle_length = cl; num_cycles = nc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Samples n negedges starting at the current one; optionally keeps feeding
  // sequential vectors (data = next_val, ff = ~next_val) whenever ready.
  task automatic capture(input int n, input bit push_on);
    load_bits = '0; xfer_bits = '0; done_bits = '0; tc_bits = '0;
    load_q.delete(); under_k = -1; overlap = 0; busy_cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (load_sig) begin
        load_bits[k] = 1'b1;
        load_q.push_back({ff_out, d_out});
      end
      if (transfer_sig) begin
        xfer_bits[k] = 1'b1;
        tc_bits = {tc_bits[6:0], test_cycle};
      end
      if (done) done_bits[k] = 1'b1;
      if (underrun && under_k < 0) under_k = k;
      if ((load_sig && transfer_sig) || load_ff !== load_sig || transfer_ff !== transfer_sig)
        overlap++;
      if (busy) busy_cnt++;
      if (push_on) begin
        logic [7:0] v;
        v = next_val[7:0];
        vec_valid = 1'b1; vec_data = v; vec_ff = ~v; vec_tsel = 1'b0;
        if (vec_ready) next_val++;
      end
      @(negedge clk);
    end
    vec_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; vec_valid = 1'b1;
    vec_data = 8'h55; vec_ff = 8'h55; vec_tsel = 1'b1;
    cycle_length = 8'd4; num_cycles = 16'd3;
    repeat (2) @(negedge clk);
    total++;
    if ({d_out, ff_out, load_sig, load_ff, transfer_sig, transfer_ff, test_cycle,
         en_ff_logic, busy, done, underrun, cyc_cnt} !== '0) begin
      bad++; $display("FAIL reset_outputs busy=%b cyc=%0d load=%b got nonzero, exp all 0", busy, cyc_cnt, load_sig);
    end
    vec_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    total++;
    if (vec_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", vec_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    push_vec(8'h01, 8'hF0, 1'b0);
    push_vec(8'h02, 8'h0F, 1'b1);
    push_vec(8'h04, 8'h3C, 1'b0);
    start_run(8'd4, 16'd3);
    capture(18, 1'b0);
    total++; if (load_bits !== 64'h8A) begin bad++; $display("FAIL basic_load got=%h exp=8a", load_bits); end
    total++; if (xfer_bits !== 64'h444) begin bad++; $display("FAIL basic_xfer got=%h exp=444", xfer_bits); end
    total++; if (done_bits !== 64'h8000) begin bad++; $display("FAIL basic_done got=%h exp=8000", done_bits); end
    total++; if (tc_bits !== 8'b010) begin bad++; $display("FAIL basic_tc_seq got=%b exp=010", tc_bits); end
    total++;
    if (load_q.size() != 3 || load_q[0] !== 16'hF001 || load_q[1] !== 16'h0F02 || load_q[2] !== 16'h3C04) begin
      bad++; $display("FAIL basic_load_data got n=%0d first=%h exp f001 0f02 3c04", load_q.size(),
                      (load_q.size() > 0) ? load_q[0] : 16'h0);
    end
    total++; if (cyc_cnt !== 16'd3) begin bad++; $display("FAIL basic_cyc_cnt got=%0d exp=3", cyc_cnt); end
    total++; if (under_k != -1) begin bad++; $display("FAIL basic_underrun got_k=%0d exp=none", under_k); end
    total++; if (overlap != 0) begin bad++; $display("FAIL basic_strobe_overlap got=%0d exp=0", overlap); end
    total++; if (busy !== 1'b0 || en_ff_logic !== 1'b0) begin bad++; $display("FAIL basic_end_idle busy=%b en=%b exp 0 0", busy, en_ff_logic); end
  endtask

  task automatic test_underrun();
    do_reset();
    push_vec(8'hAA, 8'h55, 1'b1);
    start_run(8'd5, 16'd3);
    capture(21, 1'b0);
    total++; if (under_k != 3) begin bad++; $display("FAIL underrun_k got=%0d exp=3", under_k); end
    total++; if (load_bits !== 64'h2) begin bad++; $display("FAIL underrun_load got=%h exp=2", load_bits); end
    total++; if (xfer_bits !== 64'h1084) begin bad++; $display("FAIL underrun_xfer got=%h exp=1084", xfer_bits); end
    total++; if (done_bits !== 64'h40000) begin bad++; $display("FAIL underrun_done got=%h exp=40000", done_bits); end
    total++; if (tc_bits !== 8'b111) begin bad++; $display("FAIL underrun_tc got=%b exp=111", tc_bits); end
    total++; if (cyc_cnt !== 16'd3 || underrun !== 1'b1) begin bad++; $display("FAIL underrun_end cyc=%0d uf=%b exp 3 1", cyc_cnt, underrun); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    next_val = 0;
    capture(20, 1'b1);
    vec_valid = 1'b1;
    total++; if (next_val != 16) begin bad++; $display("FAIL full_accepts got=%0d exp=16", next_val); end
    total++; if (vec_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", vec_ready); end
    start_run(8'd2, 16'd20);
    capture(46, 1'b1);
    total++; if (load_bits !== 64'h0000_00AA_AAAA_AAAA) begin bad++; $display("FAIL full_load got=%h exp=aaaaaaaaaa", load_bits); end
    total++; if (done_bits !== (64'd1 << 43)) begin bad++; $display("FAIL full_done got=%h exp=bit43", done_bits); end
    total++; if (load_q.size() != 20) begin bad++; $display("FAIL full_nload got=%0d exp=20", load_q.size()); end
    for (int i = 0; i < 20 && i < load_q.size(); i++) begin
      logic [7:0] ev;
      ev = 8'(i);
      total++;
      if (load_q[i] !== {~ev, ev}) begin bad++; $display("FAIL full_order[%0d] got=%h exp=%h", i, load_q[i], {~ev, ev}); end
    end
    total++; if (under_k != -1 || overlap != 0) begin bad++; $display("FAIL full_clean under_k=%0d overlap=%0d exp -1 0", under_k, overlap); end
  endtask

  task automatic test_short_length();
    for (int cl = 0; cl < 2; cl++) begin
      do_reset();
      push_vec(8'h11, 8'h00, 1'b1);
      push_vec(8'h22, 8'hFF, 1'b0);
      start_run(8'(cl), 16'd2);
      capture(9, 1'b0);
      total++; if (load_bits !== 64'hA) begin bad++; $display("FAIL short%0d_load got=%h exp=a", cl, load_bits); end
      total++; if (xfer_bits !== 64'h14) begin bad++; $display("FAIL short%0d_xfer got=%h exp=14", cl, xfer_bits); end
      total++; if (done_bits !== 64'h80) begin bad++; $display("FAIL short%0d_done got=%h exp=80", cl, done_bits); end
      total++; if (tc_bits !== 8'b10 || overlap != 0) begin bad++; $display("FAIL short%0d_tc_overlap tc=%b ov=%0d exp 10 0", cl, tc_bits, overlap); end
    end
  endtask

  task automatic test_stop();
    do_reset();
    for (int i = 0; i < 4; i++) push_vec(8'(i + 1), 8'h0, 1'b0);
    start_run(8'd3, 16'd10);
    for (int k = 0; k < 9; k++) begin
      if (k == 6) begin start = 1'b1; num_cycles = 16'd0; cycle_length = 8'd9; end
      if (k == 7) begin
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || cyc_cnt !== 16'd1) begin bad++; $display("FAIL stop_start_ignored busy=%b cyc=%0d exp 1 1", busy, cyc_cnt); end
      end
      if (k == 8) begin
        total++;
        if (cyc_cnt !== 16'd2) begin bad++; $display("FAIL stop_pre_cyc got=%0d exp=2", cyc_cnt); end
        stop = 1'b1;
      end
      @(negedge clk);
    end
    stop = 1'b0;
    total++;
    if (busy !== 1'b0 || en_ff_logic !== 1'b0 || vec_ready !== 1'b1 || done !== 1'b0 ||
        load_sig !== 1'b0 || transfer_sig !== 1'b0) begin
      bad++; $display("FAIL stop_idle busy=%b en=%b rdy=%b done=%b ld=%b xf=%b exp 0 0 1 0 0 0",
                      busy, en_ff_logic, vec_ready, done, load_sig, transfer_sig);
    end
    total++; if (cyc_cnt !== 16'd2) begin bad++; $display("FAIL stop_cyc_hold got=%0d exp=2", cyc_cnt); end
    capture(4, 1'b0);
    total++; if (done_bits !== 64'h0) begin bad++; $display("FAIL stop_no_done got=%h exp=0", done_bits); end
    // With the FIFO flushed a new run must sit in PRIME without loading.
    start_run(8'd2, 16'd1);
    capture(6, 1'b0);
    total++; if (load_bits !== 64'h0 || busy_cnt != 6) begin bad++; $display("FAIL stop_flushed load=%h busy=%0d exp 0 6", load_bits, busy_cnt); end
    total++; if (cyc_cnt !== 16'd0) begin bad++; $display("FAIL stop_restart_clear got=%0d exp=0", cyc_cnt); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_prime_abort busy=%b exp=0", busy); end
  endtask

  task automatic test_zero_cycles();
    do_reset();
    push_vec(8'h77, 8'h00, 1'b1);
    start_run(8'd4, 16'd0);
    capture(6, 1'b0);
    total++; if (done_bits !== 64'h1) begin bad++; $display("FAIL zero_done got=%h exp=1", done_bits); end
    total++; if (load_bits !== 64'h0 || xfer_bits !== 64'h0) begin bad++; $display("FAIL zero_strobes load=%h xfer=%h exp 0 0", load_bits, xfer_bits); end
    total++; if (busy_cnt != 0) begin bad++; $display("FAIL zero_busy got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    push_vec(8'h99, 8'h66, 1'b1);
    push_vec(8'h98, 8'h67, 1'b1);
    start_run(8'd4, 16'd5);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({d_out, ff_out, load_sig, transfer_sig, test_cycle, en_ff_logic, busy, done,
         underrun, cyc_cnt} !== '0 || vec_ready !== 1'b1) begin
      bad++; $display("FAIL midrun_reset busy=%b en=%b tc=%b d=%h rdy=%b exp all 0 rdy 1",
                      busy, en_ff_logic, test_cycle, d_out, vec_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_fifo_full();
    test_short_length();
    test_stop();
    test_zero_cycles();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Upstream timing/sequencing stage for a bank of NUM_CH double-buffered formatter channels.
- Host pushes test vectors over a valid/ready interface. Each vector holds per-channel data, per-channel format select and a leading-edge select.
- The block buffers vectors in a FIFO and paces them one per test cycle. Per cycle it generates the load/transfer strobes, EN_FF_LOGIC and TEST_CYCLE that the formatter channels consume.

Parameters:
- NUM_CH, 8, number of formatter channels driven in parallel.
- FIFO_DEPTH, 16, vector FIFO entries; power of 2, minimum 2.
- NCYC_W, 16, width of the test-cycle count.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; latches CYCLE_LENGTH and NUM_CYCLES and begins a run; ignored unless IDLE.
- STOP  in  1  one-cycle pulse; aborts the run and flushes the FIFO.
- CYCLE_LENGTH  in  8  clocks per test cycle; sampled on START.
- NUM_CYCLES  in  NCYC_W  test cycles per run; sampled on START.
- VEC_VALID  in  1  host vector valid.
- VEC_READY  out  1  FIFO not full.
- VEC_DATA  in  NUM_CH  per-channel signal value.
- VEC_FF  in  NUM_CH  per-channel format (0 = R0, 1 = DNRZ_L).
- VEC_TSEL  in  1  leading-edge select for this vector.
- D_OUT  out  NUM_CH  vector data, valid while LOAD_SIG is high.
- FF_OUT  out  NUM_CH  vector format, valid while LOAD_FF is high.
- LOAD_SIG  out  1  load strobe to channel buffers.
- LOAD_FF  out  1  equal to LOAD_SIG.
- TRANSFER_SIG  out  1  transfer strobe at the test-cycle boundary.
- TRANSFER_FF  out  1  equal to TRANSFER_SIG.
- TEST_CYCLE  out  1  leading-edge select of the active vector.
- EN_FF_LOGIC  out  1  enables channel edge counters while running.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle pulse at normal run completion.
- UNDERRUN  out  1  sticky flag: FIFO was empty at a load slot.
- CYC_CNT  out  NCYC_W  test cycles completed in the current run.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE. The exception is VEC_READY, which is 1 from the first cycle after reset.
- FIFO:
  - Push on VEC_VALID & VEC_READY; pop only by the FSM.
  - VEC_READY = (count != FIFO_DEPTH).
  - Push and pop in the same cycle leave count unchanged.
  - No empty-to-pop bypass: a vector is poppable the cycle after its push.
  - Pointers wrap modulo FIFO_DEPTH.
- Effective cycle length L = max(latched CYCLE_LENGTH, 2).
- States: IDLE, PRIME, ARM, RUN, FINISH.
- IDLE:
  - START with NUM_CYCLES == 0: DONE pulses next cycle; stay IDLE.
  - START otherwise: latch parameters, CYC_CNT <= 0, UNDERRUN <= 0, go to PRIME.
- PRIME:
  - Wait while the FIFO is empty (no timeout).
  - When non-empty: pop, assert LOAD_SIG/LOAD_FF for 1 cycle with D_OUT/FF_OUT = popped entry, go to ARM.
- ARM:
  - Assert TRANSFER_SIG/TRANSFER_FF for 1 cycle.
  - TEST_CYCLE <= popped TSEL.
  - Phase <= 0, EN_FF_LOGIC <= 1, go to RUN.
- RUN (phase counts 0..L-1, then wraps to 0):
  - Phase == 0: if CYC_CNT + 1 < NUM_CYCLES, this is a load slot.
    - FIFO non-empty: pop, pulse LOAD, hold the entry as pending.
    - FIFO empty: set UNDERRUN, no LOAD, pending stays the previous vector (the previous vector repeats).
  - Phase == L-1: CYC_CNT <= CYC_CNT + 1.
    - If CYC_CNT + 1 == NUM_CYCLES, go to FINISH with no TRANSFER.
    - Otherwise pulse TRANSFER and set TEST_CYCLE <= pending TSEL on the same edge.
- FINISH: EN_FF_LOGIC <= 0, DONE pulse 1 cycle, TEST_CYCLE holds, go to IDLE.
- STOP in any state (wins over everything except RST):
  - Next cycle: IDLE, all strobes and EN_FF_LOGIC 0, FIFO flushed, no DONE.
  - CYC_CNT and UNDERRUN hold.
- START while BUSY: ignored.
- Host pushes during RUN are accepted normally.
- At most one LOAD and one TRANSFER per test cycle. LOAD and TRANSFER never coincide, because L >= 2.
- Latched CYCLE_LENGTH and NUM_CYCLES are unaffected by input changes mid-run.
- RST mid-run: immediate return to reset values on the next edge.

Test Plan:
- Push 3 vectors (DATA 0x01/0x02/0x04, TSEL 0/1/0), CYCLE_LENGTH = 4, NUM_CYCLES = 3, START:
  - LOAD at PRIME, TRANSFER 1 cycle later.
  - Subsequent TRANSFERs exactly 4 clocks apart, 2 total after ARM.
  - TEST_CYCLE sequence 0,1,0.
  - DONE 1 cycle after the 3rd boundary; CYC_CNT = 3; UNDERRUN = 0.
- Push only 1 vector, NUM_CYCLES = 3, CYCLE_LENGTH = 5:
  - UNDERRUN rises at the first RUN phase 0.
  - No further LOAD pulses; TRANSFERs continue every 5 clocks.
  - DONE asserted; CYC_CNT = 3.
- Hold VEC_VALID high from reset with no run:
  - Exactly 16 pushes accepted; VEC_READY low after the 16th.
  - With full FIFO plus simultaneous push/pop during RUN, count stays at 16 and no data is lost (verified by popped order).
- CYCLE_LENGTH = 0 and 1 with NUM_CYCLES = 2:
  - Period behaves as L = 2, TRANSFER every 2 clocks.
  - LOAD and TRANSFER never in the same cycle.
- STOP pulse mid-RUN at CYC_CNT = 2:
  - Next cycle BUSY = 0, EN_FF_LOGIC = 0, VEC_READY = 1, FIFO empty, no DONE.
  - A second START during BUSY earlier is ignored (CYC_CNT not cleared).
- NUM_CYCLES = 0 START: no LOAD/TRANSFER, DONE pulse next cycle, BUSY stays 0.
